// File: rtl/chain_segment_relax.sv
// chain_segment_relax: one rope segment relaxed by Gauss-Seidel sweeps.
// A single shared datapath updates one node per cycle.
`default_nettype none

module chain_segment_relax #(
  parameter int NODES   = 5,
  parameter int COORD_W = 32,
  parameter int CORE_ID = 1,
  parameter int SPACING = 16,
  parameter int ITER_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ITER_W-1:0]          iterations,
  input  logic [1:0]                 mode,
  input  logic                       is_last,
  input  logic [COORD_W-1:0]         prev_core_last_x,
  input  logic [COORD_W-1:0]         prev_core_last_y,
  input  logic [COORD_W-1:0]         next_core_first_x,
  input  logic [COORD_W-1:0]         next_core_first_y,
  input  logic [COORD_W-1:0]         x_mouse,
  input  logic [COORD_W-1:0]         y_mouse,
  output logic [NODES*COORD_W-1:0]   nodes_x,
  output logic [NODES*COORD_W-1:0]   nodes_y,
  output logic                       busy,
  output logic                       done,
  output logic [ITER_W-1:0]          sweep_idx
);

  localparam int IDX_W = (NODES > 2) ? $clog2(NODES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);
  localparam logic [1:0] MODE_FOLLOW = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SWEEP, S_DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [ITER_W-1:0]    iter_q;
  logic [1:0]           mode_q;
  logic [IDX_W-1:0]     idx;
  logic [COORD_W-1:0]   shadow_prev_x, shadow_prev_y;
  logic [COORD_W-1:0]   shadow_next_x, shadow_next_y;
  logic [COORD_W-1:0]   node_x [NODES];
  logic [COORD_W-1:0]   node_y [NODES];

  logic [IDX_W-1:0]     p_idx, n_idx;
  logic [COORD_W-1:0]   p_x, p_y, c_x, c_y, n_x, n_y;
  logic [COORD_W+1:0]   sum_x, sum_y;
  logic [COORD_W-1:0]   new_x, new_y;
  logic                 write_en;
  logic                 sweep_end;
  logic                 last_sweep;
  logic [ITER_W-1:0]    sweep_inc;
  logic                 unused_sum_bits;

  // Neighbour selection: segment boundaries fall back to the latched shadows.
  always_comb begin
    p_idx = (idx == '0) ? '0 : idx - 1'b1;
    n_idx = (idx == LAST_IDX) ? idx : idx + 1'b1;
    p_x   = (idx == '0) ? shadow_prev_x : node_x[p_idx];
    p_y   = (idx == '0) ? shadow_prev_y : node_y[p_idx];
    n_x   = (idx == LAST_IDX) ? shadow_next_x : node_x[n_idx];
    n_y   = (idx == LAST_IDX) ? shadow_next_y : node_y[n_idx];
    c_x   = node_x[idx];
    c_y   = node_y[idx];
  end

  // (P + 2C + N) in COORD_W+2 bits; dropping the two LSBs is the floor divide by 4.
  assign sum_x = {{2{p_x[COORD_W-1]}}, p_x} + {c_x[COORD_W-1], c_x, 1'b0}
               + {{2{n_x[COORD_W-1]}}, n_x};
  assign sum_y = {{2{p_y[COORD_W-1]}}, p_y} + {c_y[COORD_W-1], c_y, 1'b0}
               + {{2{n_y[COORD_W-1]}}, n_y};
  assign new_x = sum_x[COORD_W+1:2];
  assign new_y = sum_y[COORD_W+1:2];
  assign unused_sum_bits = &{1'b0, sum_x[1:0], sum_y[1:0]};

  assign write_en = (state == S_SWEEP) && (mode_q != MODE_FREEZE)
                 && !((CORE_ID == 1) && (idx == '0))
                 && !(is_last && (idx == LAST_IDX));

  assign sweep_end  = (state == S_SWEEP) && (idx == LAST_IDX);
  assign sweep_inc  = sweep_idx + 1'b1;
  assign last_sweep = (sweep_inc == iter_q);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LATCH;
      S_LATCH: state_next = (iter_q == '0) ? S_DONE : S_SWEEP;
      S_SWEEP: if (sweep_end && last_sweep) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      iter_q        <= '0;
      mode_q        <= '0;
      idx           <= '0;
      sweep_idx     <= '0;
      shadow_prev_x <= '0;
      shadow_prev_y <= '0;
      shadow_next_x <= '0;
      shadow_next_y <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            iter_q    <= iterations;
            mode_q    <= mode;
            sweep_idx <= '0;
          end
        end
        S_LATCH: begin
          shadow_prev_x <= prev_core_last_x;
          shadow_prev_y <= prev_core_last_y;
          shadow_next_x <= next_core_first_x;
          shadow_next_y <= next_core_first_y;
          idx           <= '0;
        end
        S_SWEEP: begin
          if (idx == LAST_IDX) begin
            idx       <= '0;
            sweep_idx <= sweep_inc;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NODES; i++) begin
        node_x[i] <= COORD_W'(((CORE_ID - 1) * NODES + i + 1) * SPACING);
        node_y[i] <= '0;
      end
    end else if ((state == S_LATCH) && (CORE_ID == 1) && (mode_q == MODE_FOLLOW)) begin
      node_x[0] <= x_mouse;
      node_y[0] <= y_mouse;
    end else if (write_en) begin
      node_x[idx] <= new_x;
      node_y[idx] <= new_y;
    end
  end

  for (genvar g = 0; g < NODES; g++) begin : g_pack
    assign nodes_x[g*COORD_W +: COORD_W] = node_x[g];
    assign nodes_y[g*COORD_W +: COORD_W] = node_y[g];
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

`default_nettype wire
